// File: rtl/cmp_result_monitor.sv
// Comparator result monitor: gathers per-window
// lt/gt/eq/error counts and the longest equal run.
module cmp_result_monitor #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] win_len,
  input  logic          in_valid,
  input  logic [2:0]    in_result,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] lt_cnt,
  output logic [CW-1:0] gt_cnt,
  output logic [CW-1:0] eq_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] max_eq_run,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    REPORT
  } state_t;

  localparam logic [CW-1:0] ZERO = '0;
  localparam logic [CW-1:0] ONE  = 1;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] len_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] lt_q;
  logic [CW-1:0] gt_q;
  logic [CW-1:0] eq_q;
  logic [CW-1:0] err_q;
  logic [CW-1:0] run_q;
  logic [CW-1:0] max_q;
  logic [CW-1:0] run_d;
  logic          start_ok;
  logic          accept;
  logic          last;
  logic          is_eq;

  assign start_ok = (state_q == IDLE)
                  && start
                  && (win_len != ZERO);
  assign accept   = in_valid && in_ready;
  assign last     = accept
                  && (cnt_q == len_q - ONE);
  assign is_eq    = (in_result == 3'b001);
  assign run_d    = is_eq ? run_q + ONE : ZERO;

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == REPORT);
  assign busy      = (state_q != IDLE);

  assign lt_cnt     = lt_q;
  assign gt_cnt     = gt_q;
  assign eq_cnt     = eq_q;
  assign err_cnt    = err_q;
  assign max_eq_run = max_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: window opens, fills, then waits for handoff
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = COLLECT;
      end
      COLLECT: begin
        if (last) state_d = REPORT;
      end
      REPORT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Window statistics; held whenever no beat is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= ZERO;
      cnt_q <= ZERO;
      lt_q  <= ZERO;
      gt_q  <= ZERO;
      eq_q  <= ZERO;
      err_q <= ZERO;
      run_q <= ZERO;
      max_q <= ZERO;
    end else if (start_ok) begin
      len_q <= win_len;
      cnt_q <= ZERO;
      lt_q  <= ZERO;
      gt_q  <= ZERO;
      eq_q  <= ZERO;
      err_q <= ZERO;
      run_q <= ZERO;
      max_q <= ZERO;
    end else if (accept) begin
      cnt_q <= cnt_q + ONE;
      unique case (1'b1)
        (in_result == 3'b100): lt_q <= lt_q + ONE;
        (in_result == 3'b010): gt_q <= gt_q + ONE;
        (in_result == 3'b001): eq_q <= eq_q + ONE;
        default:               err_q <= err_q + ONE;
      endcase
      run_q <= run_d;
      if (run_d > max_q) max_q <= run_d;
    end
  end

endmodule

// File: doc/cmp_result_monitor.md
CMP_RESULT_MONITOR -- requirements
Module: cmp_result_monitor

Interface
REQ-001 SHALL have parameter CW, default 8, giving the width of win_len and of all count outputs.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a window; honoured only in IDLE.
REQ-005 SHALL have port win_len  input  CW  number of results per window; sampled when start is accepted.
REQ-006 SHALL have port in_valid  input  1  upstream comparator result is valid.
REQ-007 SHALL have port in_result  input  3  comparator code: [2] a<b, [1] a>b, [0] a=b.
REQ-008 SHALL have port in_ready  output  1  monitor accepts in_result this cycle.
REQ-009 SHALL have port out_valid  output  1  window summary valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the summary.
REQ-011 SHALL have ports lt_cnt, gt_cnt, eq_cnt, err_cnt, max_eq_run  output  CW each  window statistics.
REQ-012 SHALL have port busy  output  1  high when the state is not IDLE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, COLLECT, REPORT.
REQ-014 In IDLE with start=1 and win_len!=0, SHALL latch win_len, clear all counters and the run register, and enter COLLECT on the next edge.
REQ-015 In IDLE with start=1 and win_len=0, SHALL ignore start and remain in IDLE.
REQ-016 SHALL drive in_ready=1 only in COLLECT; a beat is accepted when in_valid and in_ready are both 1 on an edge.
REQ-017 SHALL classify each accepted beat as follows: 3'b100 increments lt_cnt; 3'b010 increments gt_cnt; 3'b001 increments eq_cnt; any other code (000, 011, 101, 110, 111) increments err_cnt only.
REQ-018 SHALL keep a current equal-run counter: +1 on an accepted 3'b001 beat, cleared to 0 on any other accepted beat.
REQ-019 SHALL update max_eq_run to max(max_eq_run, new run value) on the same edge as the run counter.
REQ-020 SHALL leave all counters and the run register unchanged on cycles with no accepted beat, including in_valid=0 gaps.
REQ-021 SHALL enter REPORT on the edge that accepts beat number win_len; in_ready SHALL be 0 from the next cycle.
REQ-022 Invariant: at entry to REPORT, lt_cnt+gt_cnt+eq_cnt+err_cnt = latched win_len; no counter wraps, since each is bounded by win_len ≤ 2^CW-1.
REQ-023 In REPORT SHALL hold out_valid=1 with all statistics stable until out_ready=1, then return to IDLE on that edge.
REQ-024 SHALL hold the statistics in IDLE after the handshake, until the next accepted start clears them.
REQ-025 SHALL drive out_valid=0 outside REPORT.
REQ-026 SHALL ignore start in COLLECT and REPORT; it SHALL NOT restart or alter an active window.
REQ-027 When start is accepted and a valid beat arrives in the same cycle, the beat SHALL NOT be accepted, because in_ready is 0 in IDLE.
REQ-028 SHALL have zero-cycle combinational paths only from state to in_ready, out_valid and busy; all statistics SHALL be registered.

Reset
REQ-029 On rst_n=0, SHALL immediately enter IDLE, independent of clk.
REQ-030 On rst_n=0, SHALL immediately drive in_ready=0, out_valid=0 and busy=0.
REQ-031 On rst_n=0, SHALL immediately clear all counts, max_eq_run, the run register and the latched win_len to 0.
REQ-032 Reset asserted mid-COLLECT or mid-REPORT SHALL discard the window; after release, the block SHALL wait in IDLE for a new start.

Verification
REQ-033 Window: win_len=4, beats 100, 010, 001, 001 -> REPORT with lt=1, gt=1, eq=2, err=0, max_eq_run=2.
REQ-034 Errors and runs: win_len=6, beats 001, 001, 111, 001, 000, 001 -> lt=0, gt=0, eq=4, err=2, max_eq_run=2.
REQ-035 Backpressure: win_len=2 with in_valid gaps between beats, then out_ready held 0 for 5 cycles -> counts unchanged during the gaps; out_valid stays 1 with stable counts for 5 cycles; IDLE one edge after out_ready=1.
REQ-036 Control corners: start with win_len=0 -> busy stays 0; start pulsed during COLLECT -> counts unaffected.
REQ-037 Reset mid-window: rst_n pulsed low after 3 of 8 beats -> all outputs 0 immediately; a following start with win_len=1 and beat 010 -> gt=1 only.
REQ-038 Maximum window: win_len=255 (CW=8), all beats 001 -> eq=255, max_eq_run=255, no wrap.
